sysctl_regfile: RTL and testbench
=================================

Name: sysctl_regfile

Overview:
- Register bank of the System Controller peripheral. It sits directly downstream of the Wishbone slave interface stage.
- Consumes that stage's one-cycle we/re strobes, registered address, write data and byte selects. Returns read data, error and interrupt back to it.
- Holds control and scratch registers, a prescaled 32-bit timer with compare, and an interrupt controller for the timer plus external sources.

Parameters:
ID_VALUE, 32'h5C00_0001, value returned by the ID register
N_EXT, 4, number of external interrupt sources (1..31)
PRESCALE_RST, 16'd0, reset value of the PRESCALE register

Ports:
clk  in  1  system clock
wb_rst_i  in  1  asynchronous, active-high reset
we_i  in  1  write strobe, one-cycle pulse per transfer
re_i  in  1  read strobe, one-cycle pulse per transfer
adr_i  in  6  byte address; word index = adr_i[5:2]
wdata_i  in  32  write data
sel_i  in  4  byte enables; sel_i[k] covers bits [8k+7:8k]
rdata_o  out  32  read data, combinational decode of adr_i
err_o  out  1  error indication to the interface stage
irq_o  out  1  interrupt request, level
ext_irq_i  in  N_EXT  asynchronous external interrupt sources
periph_en_o  out  8  peripheral enable bits, CTRL[15:8]
soft_rst_o  out  1  one-cycle soft-reset pulse

Behaviour:
- Reset values: all registers 0 except PRESCALE=PRESCALE_RST. All outputs 0.
- Register map (offset, access):
  - 0x00 ID, RO.
  - 0x04 CTRL, RW: [0] tmr_en, [1] autoreload, [2] soft_rst (self-clearing, reads 0), [15:8] periph_en.
  - 0x08 STATUS, RO: [0] tmr_en & prescaler active, [1] irq_o.
  - 0x0C SCRATCH, RW.
  - 0x10 TMR_CNT, RW.
  - 0x14 TMR_CMP, RW.
  - 0x18 PRESCALE, RW, [15:0] only.
  - 0x1C IRQ_RAW, RO: [0] match level (cnt==cmp), [N_EXT:1] synced ext levels.
  - 0x20 IRQ_EN, RW, bits [N_EXT:0].
  - 0x24 IRQ_PEND, W1C.
  - 0x28–0x3C unmapped; reads return 0.
- Writes:
  - Take effect on the clk edge where we_i=1, per sel_i byte.
  - Writes to RO or unmapped locations are ignored.
  - Writing CTRL[2]=1 produces soft_rst_o=1 on the next cycle only.
- Reads:
  - rdata_o is a pure combinational function of adr_i and register state. The interface stage registers it one cycle later.
  - re_i has no side effects except the optional error path.
- Prescaler:
  - 16-bit counter pc runs only while tmr_en=1.
  - tick=1 when pc==PRESCALE, then pc wraps to 0. PRESCALE=0 gives a tick every cycle.
  - tmr_en=0 holds pc at 0.
- Timer:
  - On tick, cnt increments mod 2^32.
  - A match event fires on a tick where cnt==cmp. On that tick, cnt loads 0 if autoreload=1, else cnt+1.
- External interrupts:
  - Each ext_irq_i bit passes through a 2-flop synchroniser.
  - A rising edge of the synced level is an event.
- Pending:
  - pend[i] sets on event i.
  - pend[i] clears on an IRQ_PEND write with wdata bit i=1 and sel covering that byte.
  - A set and a clear in the same cycle: set wins.
- irq_o = |(pend & IRQ_EN), registered, so it follows a pend change by one cycle.
- Simultaneous events:
  - A TMR_CNT write and a tick in the same cycle: the write wins, no match evaluated that cycle.
  - A PRESCALE write resets pc to 0.
- Reset mid-operation: asynchronous clear of all state, including synchronisers. The soft_rst pulse does not reset this block.

Optional Feature:
- Macro SYSCTL_ADDR_ERR_EN.
- Defined: err_o=1 for one cycle following any we_i/re_i to an unmapped offset, or a we_i to an RO offset (0x00, 0x08, 0x1C). Register state is unchanged.
- Undefined: err_o tied 0.

Decomposition:
- Package sysctl_pkg holds:
  - offset localparams (SYSCTL_ID_OFS … SYSCTL_PEND_OFS);
  - CTRL bit-index constants;
  - a typedef struct packed for CTRL fields;
  - the byte-mask helper function applying sel to a 32-bit write.
- One natural sub-module, sysctl_timer: prescaler + counter + match, with inputs tmr_en, autoreload, prescale, cmp and cnt write port, and outputs cnt and match_evt.

Test Plan:
- Reset → rdata at 0x00 = 32'h5C00_0001; CTRL, PEND, irq_o, periph_en_o all 0; PRESCALE = 0.
- Write 0x0C data 32'hAABBCCDD sel=4'b0101 over prior 0 → reads 32'h00BB00DD.
- PRESCALE=3, CMP=5, autoreload=1, EN bit0=1, tmr_en=1 → match after 24 cycles; cnt returns to 0; irq_o rises 1 cycle after pend[0]; write 0x24=1 clears it.
- ext_irq_i[2] held high → pend[3] set once, 3 cycles after the edge (2 sync + edge detect); held level does not re-set after W1C.
- W1C of pend[0] in the same cycle as a new match → pend[0] stays 1.
- CTRL write 32'h0000_A504 → periph_en_o=8'hA5, soft_rst_o pulses exactly 1 cycle, CTRL reads 32'h0000_A500. With SYSCTL_ADDR_ERR_EN, a write to 0x30 → err_o 1-cycle pulse, no state change.

Source files
------------

// File: rtl/sysctl_pkg.sv
// Shared definitions for the System Controller register bank.
// Holds register offsets, CTRL field layout and the byte-lane write helpers.
// The optional address-error path is selected by the SYSCTL_ADDR_ERR_EN macro
// in sysctl_regfile.
package sysctl_pkg;

  localparam int unsigned SYSCTL_AW = 6;
  localparam int unsigned SYSCTL_DW = 32;

  // Byte offsets of the mapped registers; 0x28..0x3C are unmapped.
  localparam logic [SYSCTL_AW-1:0] SYSCTL_ID_OFS       = 6'h00;
  localparam logic [SYSCTL_AW-1:0] SYSCTL_CTRL_OFS     = 6'h04;
  localparam logic [SYSCTL_AW-1:0] SYSCTL_STATUS_OFS   = 6'h08;
  localparam logic [SYSCTL_AW-1:0] SYSCTL_SCRATCH_OFS  = 6'h0C;
  localparam logic [SYSCTL_AW-1:0] SYSCTL_CNT_OFS      = 6'h10;
  localparam logic [SYSCTL_AW-1:0] SYSCTL_CMP_OFS      = 6'h14;
  localparam logic [SYSCTL_AW-1:0] SYSCTL_PRESCALE_OFS = 6'h18;
  localparam logic [SYSCTL_AW-1:0] SYSCTL_RAW_OFS      = 6'h1C;
  localparam logic [SYSCTL_AW-1:0] SYSCTL_EN_OFS       = 6'h20;
  localparam logic [SYSCTL_AW-1:0] SYSCTL_PEND_OFS     = 6'h24;

  // Drops the byte-within-word bits of the address.
  localparam logic [SYSCTL_AW-1:0] SYSCTL_WORD_MASK    = 6'h3C;

  // CTRL bit positions.
  localparam int unsigned CTRL_TMR_EN_BIT     = 0;
  localparam int unsigned CTRL_AUTORELOAD_BIT = 1;
  localparam int unsigned CTRL_SOFT_RST_BIT   = 2;
  localparam int unsigned CTRL_PERIPH_LSB     = 8;
  localparam int unsigned CTRL_PERIPH_W       = 8;

  // Stored CTRL fields; soft_rst is a pulse and is not stored.
  typedef struct packed {
    logic [CTRL_PERIPH_W-1:0] periph_en;
    logic                     autoreload;
    logic                     tmr_en;
  } ctrl_t;

  // Expands byte enables into a 32-bit bit mask.
  function automatic logic [SYSCTL_DW-1:0] sel_mask(input logic [3:0] sel);
    logic [SYSCTL_DW-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{sel[k]}};
    end
    return m;
  endfunction

  // Applies a byte-enabled write on top of the current register value.
  function automatic logic [SYSCTL_DW-1:0] byte_merge(input logic [SYSCTL_DW-1:0] cur,
                                                      input logic [SYSCTL_DW-1:0] wdata,
                                                      input logic [3:0]           sel);
    logic [SYSCTL_DW-1:0] m;
    m = sel_mask(sel);
    return (cur & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/sysctl_timer.sv
// Prescaled 32-bit timer with compare.
// Ports: clk/wb_rst_i; tmr_en, autoreload, prescale, prescale_we (restarts the
// prescaler), cmp, cnt_we/cnt_wdata (software load of the counter);
// outputs cnt and match_evt (combinational, valid in the cycle of the tick).
module sysctl_timer
  import sysctl_pkg::*;
(
  input  logic                 clk,
  input  logic                 wb_rst_i,
  input  logic                 tmr_en,
  input  logic                 autoreload,
  input  logic [15:0]          prescale,
  input  logic                 prescale_we,
  input  logic [SYSCTL_DW-1:0] cmp,
  input  logic                 cnt_we,
  input  logic [SYSCTL_DW-1:0] cnt_wdata,
  output logic [SYSCTL_DW-1:0] cnt,
  output logic                 match_evt
);

  logic [15:0] pc_q;
  logic        tick;

  assign tick      = tmr_en && (pc_q == prescale);
  // A software load of the counter suppresses match evaluation that cycle.
  assign match_evt = tick && !cnt_we && (cnt == cmp);

  // Prescaler: held at 0 while disabled, restarted by a PRESCALE write.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pc_q <= '0;
    end else if (!tmr_en || prescale_we || tick) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_q + 16'd1;
    end
  end

  // Counter: software write wins over a tick.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (cnt_we) begin
      cnt <= cnt_wdata;
    end else if (tick) begin
      if (autoreload && (cnt == cmp)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/sysctl_regfile.sv
// System Controller register bank behind the Wishbone interface stage.
// Ports: clk, wb_rst_i (async, active high); we_i/re_i one-cycle strobes,
// adr_i byte address, wdata_i, sel_i byte enables; rdata_o (combinational
// decode of adr_i), err_o, irq_o (level); ext_irq_i async sources;
// periph_en_o (CTRL[15:8]); soft_rst_o one-cycle pulse.
// Optional macro SYSCTL_ADDR_ERR_EN: flags accesses to unmapped offsets and
// writes to read-only offsets on err_o; otherwise err_o is tied low.
module sysctl_regfile
  import sysctl_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h5C00_0001,
  parameter int unsigned N_EXT        = 4,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [5:0]       adr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       sel_i,
  output logic [31:0]      rdata_o,
  output logic             err_o,
  output logic             irq_o,
  input  logic [N_EXT-1:0] ext_irq_i,
  output logic [7:0]       periph_en_o,
  output logic             soft_rst_o
);

  localparam int unsigned IRQ_W = N_EXT + 1;

  logic [SYSCTL_AW-1:0] ofs;
  logic wr_ctrl, wr_scratch, wr_cnt, wr_cmp, wr_prescale, wr_en, wr_pend;

  ctrl_t                ctrl_q;
  logic [SYSCTL_DW-1:0] ctrl_rd;
  logic [SYSCTL_DW-1:0] scratch_q;
  logic [SYSCTL_DW-1:0] cmp_q;
  logic [15:0]          prescale_q;
  logic [IRQ_W-1:0]     irq_en_q;
  logic [IRQ_W-1:0]     pend_q;
  logic [IRQ_W-1:0]     pend_set;
  logic [IRQ_W-1:0]     pend_clr;
  logic [N_EXT-1:0]     ext_s1, ext_s2, ext_s3;
  logic                 irq_q;
  logic                 soft_rst_q;
  logic [SYSCTL_DW-1:0] tmr_cnt;
  logic                 match_evt;

  assign ofs = adr_i & SYSCTL_WORD_MASK;

  assign wr_ctrl     = we_i && (ofs == SYSCTL_CTRL_OFS);
  assign wr_scratch  = we_i && (ofs == SYSCTL_SCRATCH_OFS);
  assign wr_cnt      = we_i && (ofs == SYSCTL_CNT_OFS);
  assign wr_cmp      = we_i && (ofs == SYSCTL_CMP_OFS);
  assign wr_prescale = we_i && (ofs == SYSCTL_PRESCALE_OFS);
  assign wr_en       = we_i && (ofs == SYSCTL_EN_OFS);
  assign wr_pend     = we_i && (ofs == SYSCTL_PEND_OFS);

  assign ctrl_rd = {16'h0, ctrl_q.periph_en, 6'h0, ctrl_q.autoreload, ctrl_q.tmr_en};

  sysctl_timer u_timer (
    .clk         (clk),
    .wb_rst_i    (wb_rst_i),
    .tmr_en      (ctrl_q.tmr_en),
    .autoreload  (ctrl_q.autoreload),
    .prescale    (prescale_q),
    .prescale_we (wr_prescale),
    .cmp         (cmp_q),
    .cnt_we      (wr_cnt),
    .cnt_wdata   (byte_merge(tmr_cnt, wdata_i, sel_i)),
    .cnt         (tmr_cnt),
    .match_evt   (match_evt)
  );

  // Software-visible registers.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_q     <= '0;
      scratch_q  <= '0;
      cmp_q      <= '0;
      prescale_q <= PRESCALE_RST;
      irq_en_q   <= '0;
    end else begin
      if (wr_ctrl) begin
        if (sel_i[0]) begin
          ctrl_q.tmr_en     <= wdata_i[CTRL_TMR_EN_BIT];
          ctrl_q.autoreload <= wdata_i[CTRL_AUTORELOAD_BIT];
        end
        if (sel_i[1]) begin
          ctrl_q.periph_en <= wdata_i[CTRL_PERIPH_LSB +: CTRL_PERIPH_W];
        end
      end
      if (wr_scratch)  scratch_q  <= byte_merge(scratch_q, wdata_i, sel_i);
      if (wr_cmp)      cmp_q      <= byte_merge(cmp_q, wdata_i, sel_i);
      if (wr_prescale) prescale_q <= 16'(byte_merge(32'(prescale_q), wdata_i, sel_i));
      if (wr_en)       irq_en_q   <= IRQ_W'(byte_merge(32'(irq_en_q), wdata_i, sel_i));
    end
  end

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ext_s1 <= '0;
      ext_s2 <= '0;
      ext_s3 <= '0;
    end else begin
      ext_s1 <= ext_irq_i;
      ext_s2 <= ext_s1;
      ext_s3 <= ext_s2;
    end
  end

  assign pend_set = {ext_s2 & ~ext_s3, match_evt};
  assign pend_clr = wr_pend ? IRQ_W'(wdata_i & sel_mask(sel_i)) : '0;

  // Pending bits: a new event in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  // Registered interrupt and soft-reset pulse.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_q      <= 1'b0;
      soft_rst_q <= 1'b0;
    end else begin
      irq_q      <= |(pend_q & irq_en_q);
      soft_rst_q <= wr_ctrl && sel_i[0] && wdata_i[CTRL_SOFT_RST_BIT];
    end
  end

  assign irq_o       = irq_q;
  assign soft_rst_o  = soft_rst_q;
  assign periph_en_o = ctrl_q.periph_en;

  // Read decode.
  always_comb begin
    rdata_o = '0;
    case (ofs)
      SYSCTL_ID_OFS:       rdata_o = ID_VALUE;
      SYSCTL_CTRL_OFS:     rdata_o = ctrl_rd;
      SYSCTL_STATUS_OFS:   rdata_o = {30'h0, irq_q, ctrl_q.tmr_en};
      SYSCTL_SCRATCH_OFS:  rdata_o = scratch_q;
      SYSCTL_CNT_OFS:      rdata_o = tmr_cnt;
      SYSCTL_CMP_OFS:      rdata_o = cmp_q;
      SYSCTL_PRESCALE_OFS: rdata_o = {16'h0, prescale_q};
      SYSCTL_RAW_OFS:      rdata_o = 32'({ext_s2, (tmr_cnt == cmp_q)});
      SYSCTL_EN_OFS:       rdata_o = 32'(irq_en_q);
      SYSCTL_PEND_OFS:     rdata_o = 32'(pend_q);
      default:             rdata_o = '0;
    endcase
  end

`ifdef SYSCTL_ADDR_ERR_EN
  logic unmapped, ro_ofs, err_q;

  assign unmapped = (ofs > SYSCTL_PEND_OFS);
  assign ro_ofs   = (ofs == SYSCTL_ID_OFS) || (ofs == SYSCTL_STATUS_OFS) ||
                    (ofs == SYSCTL_RAW_OFS);

  // One-cycle error pulse following a bad access.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ((we_i || re_i) && unmapped) || (we_i && ro_ofs);
    end
  end

  assign err_o = err_q;
`else
  // Reads have no side effects without the error path.
  logic unused_re;
  assign unused_re = re_i;
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_sysctl_regfile.sv
// Randomised self-checking bench for sysctl_regfile with a behavioural
// register-map model, plus directed scenarios with literal expectations.
module tb_sysctl_regfile;

  localparam int unsigned N_EXT = 4;
  localparam int unsigned IW    = N_EXT + 1;
  localparam logic [31:0] ID_VAL = 32'h5C00_0001;
  localparam logic [31:0] PMASK  = 32'((64'd1 << IW) - 64'd1);

  logic             clk = 1'b0;
  logic             wb_rst_i;
  logic             we_i, re_i;
  logic [5:0]       adr_i;
  logic [31:0]      wdata_i;
  logic [3:0]       sel_i;
  logic [31:0]      rdata_o;
  logic             err_o, irq_o, soft_rst_o;
  logic [N_EXT-1:0] ext_irq_i;
  logic [7:0]       periph_en_o;

  always #5 clk = ~clk;

  sysctl_regfile #(
    .ID_VALUE     (ID_VAL),
    .N_EXT        (N_EXT),
    .PRESCALE_RST (16'd0)
  ) dut (
    .clk         (clk),
    .wb_rst_i    (wb_rst_i),
    .we_i        (we_i),
    .re_i        (re_i),
    .adr_i       (adr_i),
    .wdata_i     (wdata_i),
    .sel_i       (sel_i),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .irq_o       (irq_o),
    .ext_irq_i   (ext_irq_i),
    .periph_en_o (periph_en_o),
    .soft_rst_o  (soft_rst_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned ecnt  = 0;
  bit          chk_on = 1'b0;

  always @(posedge clk) ecnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]      m_ctrl, m_scr, m_cnt, m_cmp, m_ien, m_pend;
  logic [15:0]      m_prs;
  int unsigned      m_pc;
  logic [N_EXT-1:0] h0, h1, h2;  // ext samples from the last three edges
  logic             m_irq, m_soft, m_err;

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction

  task automatic m_reset();
    m_ctrl = 0; m_scr = 0; m_cnt = 0; m_cmp = 0; m_ien = 0; m_pend = 0;
    m_prs = 0; m_pc = 0; h0 = 0; h1 = 0; h2 = 0;
    m_irq = 0; m_soft = 0; m_err = 0;
  endtask

  task automatic m_step();
    int          w;
    logic [31:0] msk, ev, clr;
    logic        tick, match;
    w     = int'(adr_i[5:2]);
    msk   = bmask(sel_i);
    tick  = m_ctrl[0] && (m_pc == 32'(m_prs));
    match = tick && !(we_i && w == 4) && (m_cnt == m_cmp);
    ev    = 32'({(h1 & ~h2), match});
    clr   = (we_i && w == 9) ? (wdata_i & msk) : 32'd0;
`ifdef SYSCTL_ADDR_ERR_EN
    m_err = ((we_i || re_i) && w >= 10) || (we_i && (w == 0 || w == 2 || w == 7));
`else
    m_err = 1'b0;
`endif
    m_soft = we_i && w == 1 && sel_i[0] && wdata_i[2];
    m_irq  = |(m_pend & m_ien);
    if (!m_ctrl[0] || tick || (we_i && w == 6)) m_pc = 0;
    else m_pc = m_pc + 1;
    if (we_i && w == 4) m_cnt = (m_cnt & ~msk) | (wdata_i & msk);
    else if (tick) m_cnt = (m_ctrl[1] && m_cnt == m_cmp) ? 32'd0 : m_cnt + 32'd1;
    m_pend = ((m_pend & ~clr) | ev) & PMASK;
    if (we_i) begin
      case (w)
        1: m_ctrl = ((m_ctrl & ~msk) | (wdata_i & msk)) & 32'h0000_FF03;
        3: m_scr  = (m_scr & ~msk) | (wdata_i & msk);
        5: m_cmp  = (m_cmp & ~msk) | (wdata_i & msk);
        6: m_prs  = 16'((32'(m_prs) & ~msk) | (wdata_i & msk));
        8: m_ien  = ((m_ien & ~msk) | (wdata_i & msk)) & PMASK;
        default: ;
      endcase
    end
    h2 = h1; h1 = h0; h0 = ext_irq_i;
  endtask

  function automatic logic [31:0] m_read(input int w);
    case (w)
      0: return ID_VAL;
      1: return m_ctrl;
      2: return {30'd0, m_irq, m_ctrl[0]};
      3: return m_scr;
      4: return m_cnt;
      5: return m_cmp;
      6: return {16'd0, m_prs};
      7: return 32'({h1, (m_cnt == m_cmp)});
      8: return m_ien;
      9: return m_pend;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) m_reset();
    else m_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("rdata", rdata_o, m_read(int'(adr_i[5:2])));
      check("irq_o", 32'(irq_o), 32'(m_irq));
      check("soft_rst_o", 32'(soft_rst_o), 32'(m_soft));
      check("periph_en_o", 32'(periph_en_o), 32'(m_ctrl[15:8]));
      check("err_o", 32'(err_o), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    we_i = 1'b1; adr_i = a; wdata_i = d; sel_i = s;
    cyc();
    we_i = 1'b0;
  endtask

  task automatic peek(input logic [5:0] a, input string nm, input logic [31:0] exp);
    adr_i = a;
    @(negedge clk);
    check(nm, rdata_o, exp);
    cyc();
  endtask

  initial begin
    int unsigned e0;
    logic [3:0]  w;
    wb_rst_i = 1'b1; we_i = 0; re_i = 0; adr_i = 0; wdata_i = 0; sel_i = 0; ext_irq_i = 0;
    repeat (3) cyc();
    chk_on = 1'b1;
    wb_rst_i = 1'b0;

    // Reset state.
    adr_i = 6'h00;
    @(negedge clk);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_periph", 32'(periph_en_o), 32'd0);
    cyc();
    peek(6'h00, "rst_id", 32'h5C00_0001);
    peek(6'h04, "rst_ctrl", 32'd0);
    peek(6'h24, "rst_pend", 32'd0);
    peek(6'h18, "rst_prescale", 32'd0);

    // Byte-enabled scratch write.
    wr(6'h0C, 32'hAABB_CCDD, 4'b0101);
    peek(6'h0C, "scratch_sel", 32'h00BB_00DD);

    // Timer match with autoreload and interrupt.
    wr(6'h18, 32'd3, 4'hF);
    wr(6'h14, 32'd5, 4'hF);
    wr(6'h20, 32'd1, 4'hF);
    wr(6'h04, 32'd3, 4'hF);
    e0 = ecnt;
    while (ecnt < e0 + 23) cyc();
    adr_i = 6'h24;
    @(negedge clk);
    check("pend_pre_match", rdata_o, 32'd0);
    cyc();
    @(negedge clk);
    check("pend_match_24", rdata_o, 32'd1);
    check("irq_lag", 32'(irq_o), 32'd0);
    cyc();
    adr_i = 6'h10;
    @(negedge clk);
    check("cnt_reload", rdata_o, 32'd0);
    check("irq_rise", 32'(irq_o), 32'd1);
    wr(6'h24, 32'd1, 4'hF);
    adr_i = 6'h24;
    @(negedge clk);
    check("pend_w1c", rdata_o, 32'd0);
    cyc();
    @(negedge clk);
    check("irq_fall", 32'(irq_o), 32'd0);
    // W1C lands on the edge of the next match: set wins.
    while (ecnt < e0 + 47) cyc();
    wr(6'h24, 32'd1, 4'hF);
    peek(6'h24, "pend_set_wins", 32'd1);
    wr(6'h04, 32'd0, 4'hF);
    wr(6'h24, 32'd1, 4'hF);

    // External source: three-cycle latency, level does not re-arm.
    ext_irq_i[2] = 1'b1;
    cyc(); cyc();
    adr_i = 6'h24;
    @(negedge clk);
    check("ext_latency", rdata_o, 32'd0);
    cyc();
    @(negedge clk);
    check("ext_pend", rdata_o, 32'h8);
    cyc();
    wr(6'h24, 32'h8, 4'h1);
    cyc(); cyc();
    peek(6'h24, "ext_held_level", 32'd0);

    // CTRL with soft reset pulse.
    wr(6'h04, 32'h0000_A504, 4'hF);
    adr_i = 6'h04;
    @(negedge clk);
    check("soft_pulse", 32'(soft_rst_o), 32'd1);
    check("periph_a5", 32'(periph_en_o), 32'hA5);
    check("ctrl_read", rdata_o, 32'h0000_A500);
    cyc();
    @(negedge clk);
    check("soft_one_cycle", 32'(soft_rst_o), 32'd0);
    cyc();

    // Unmapped and read-only writes.
    wr(6'h30, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
`ifdef SYSCTL_ADDR_ERR_EN
    check("err_pulse", 32'(err_o), 32'd1);
`else
    check("err_tied", 32'(err_o), 32'd0);
`endif
    cyc();
    @(negedge clk);
    check("err_clear", 32'(err_o), 32'd0);
    cyc();
    wr(6'h00, 32'd0, 4'hF);
    peek(6'h00, "id_ro", 32'h5C00_0001);
    peek(6'h0C, "scratch_kept", 32'h00BB_00DD);
    peek(6'h30, "unmapped_zero", 32'd0);

    // Randomised traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        we_i = 0; re_i = 0;
        wb_rst_i = 1'b1;
        cyc(); cyc();
        wb_rst_i = 1'b0;
        peek(6'h0C, "midrst_scratch", 32'd0);
      end
      w       = 4'($urandom_range(0, 15));
      adr_i   = {w, 2'($urandom)};
      we_i    = ($urandom_range(0, 9) < 3);
      re_i    = ($urandom_range(0, 9) < 3);
      sel_i   = 4'($urandom);
      wdata_i = $urandom;
      if (w == 4'd4 || w == 4'd5) wdata_i = $urandom_range(0, 7);
      if (w == 4'd6) wdata_i = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) ext_irq_i = N_EXT'($urandom);
      cyc();
    end
    we_i = 0; re_i = 0;
    repeat (4) cyc();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
